// File: rtl/mig_pkg.sv
// rtl/mig_pkg.sv - shared command codes, phrase type and FSM states for the MIG traffic generator
package mig_pkg;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef logic [127:0] phrase_t;

   typedef enum logic [1:0] {
      WAIT_CAL,
      IDLE,
      WRITE,
      READ
   } tg_state_t;

endpackage

// File: rtl/rd_return_fifo.sv
// rtl/rd_return_fifo.sv - first-word-fall-through buffer for MIG read returns
module rd_return_fifo #(
   parameter int WIDTH = 129,
   parameter int DEPTH = 16
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     push_in,
   input  logic [WIDTH-1:0]         push_data_in,
   input  logic                     pop_in,
   output logic [WIDTH-1:0]         pop_data_out,
   output logic                     valid_out,
   output logic [$clog2(DEPTH):0]   count_out
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;
   logic             do_pop;

   assign valid_out    = (count_q != '0);
   assign do_pop       = pop_in && valid_out;
   assign pop_data_out = mem_q[rd_ptr_q];
   assign count_out    = count_q;

   // storage array; the head entry is read combinationally so data falls through
   always_ff @(posedge clk_in) begin
      if (push_in) begin
         mem_q[wr_ptr_q] <= push_data_in;
      end
   end

   // pointers and occupancy; a push into a full buffer is only safe alongside a pop
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         assert (!(push_in && !do_pop && count_q == FULL_CNT));
         if (push_in) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_in && !do_pop)      count_q <= count_q + 1'b1;
         else if (!push_in && do_pop) count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/mig_traffic_gen.sv
// rtl/mig_traffic_gen.sv - arbitrates phrase writes and frame-buffer reads onto one MIG command port
module mig_traffic_gen
   import mig_pkg::*;
#(
   parameter int FRAME_PHRASES = 38400,
   parameter int ADDR_W        = 27,
   parameter int ADDR_STEP     = 8,
   parameter int RD_FIFO_DEPTH = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              calib_in,
   input  logic              rd_en_in,
   input  logic              wr_valid_in,
   output logic              wr_ready_in,
   input  logic [127:0]      wr_data_in,
   input  logic              wr_tuser_in,
   output logic              rd_valid_out,
   input  logic              rd_ready_out,
   output logic [127:0]      rd_data_out,
   output logic              rd_tuser_out,
   output logic [ADDR_W-1:0] app_addr,
   output logic [2:0]        app_cmd,
   output logic              app_en,
   input  logic              app_rdy,
   output logic [127:0]      app_wdf_data,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   output logic [15:0]       app_wdf_mask,
   input  logic              app_wdf_rdy,
   input  logic [127:0]      app_rd_data,
   input  logic              app_rd_data_valid
);

   localparam int CW = $clog2(FRAME_PHRASES * ADDR_STEP);
   localparam int OW = $clog2(RD_FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] STEP_C     = CW'(ADDR_STEP);
   localparam logic [CW-1:0] LAST_ADDR  = CW'((FRAME_PHRASES - 1) * ADDR_STEP);
   localparam logic [CW-1:0] LAST_PHR   = CW'(FRAME_PHRASES - 1);
   localparam logic [OW:0]   DEPTH_C    = (OW+1)'(RD_FIFO_DEPTH);
   localparam logic          GRANT_WR   = 1'b0;
   localparam logic          GRANT_RD   = 1'b1;

   tg_state_t     state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          cmd_done_q, cmd_done_d;
   logic          data_done_q, data_done_d;
   logic [CW-1:0] wr_addr_q, wr_addr_d;
   logic [CW-1:0] rd_addr_q, rd_addr_d;
   logic [CW-1:0] rd_ret_cnt_q;
   logic [OW-1:0] outstanding_q;
   logic [OW-1:0] fifo_cnt;
   logic [OW:0]   credit_sum;
   logic          rd_issue;
   logic          wr_elig, rd_elig, cmd_ok, data_ok;
   logic [128:0]  fifo_dout;

   function automatic logic [CW-1:0] next_addr(input logic [CW-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + STEP_C;
   endfunction

   assign credit_sum   = {1'b0, outstanding_q} + {1'b0, fifo_cnt};
   assign wr_elig      = wr_valid_in;
   assign rd_elig      = rd_en_in && (credit_sum < DEPTH_C);
   assign cmd_ok       = cmd_done_q || app_rdy;
   assign data_ok      = data_done_q || app_wdf_rdy;
   assign app_wdf_data = wr_data_in;
   assign app_wdf_end  = app_wdf_wren;
   assign app_wdf_mask = '0;
   assign rd_data_out  = fifo_dout[127:0];
   assign rd_tuser_out = fifo_dout[128];

   // next-state, arbitration and MIG command outputs
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cmd_done_d   = cmd_done_q;
      data_done_d  = data_done_q;
      wr_addr_d    = wr_addr_q;
      rd_addr_d    = rd_addr_q;
      app_en       = 1'b0;
      app_cmd      = CMD_WRITE;
      app_addr     = '0;
      app_wdf_wren = 1'b0;
      wr_ready_in  = 1'b0;
      rd_issue     = 1'b0;
      unique case (state_q)
         WAIT_CAL: begin
            if (calib_in) state_d = IDLE;
         end
         IDLE: begin
            if (!calib_in) begin
               state_d = WAIT_CAL;
            end else if (wr_elig && (!rd_elig || last_grant_q == GRANT_RD)) begin
               state_d      = WRITE;
               last_grant_d = GRANT_WR;
            end else if (rd_elig) begin
               state_d      = READ;
               last_grant_d = GRANT_RD;
            end
         end
         WRITE: begin
            // a frame-start phrase always lands at the base of the buffer
            app_en       = !cmd_done_q;
            app_addr     = wr_tuser_in ? '0 : ADDR_W'(wr_addr_q);
            app_wdf_wren = !data_done_q;
            cmd_done_d   = cmd_ok;
            data_done_d  = data_ok;
            if (cmd_ok && data_ok) begin
               wr_ready_in = 1'b1;
               cmd_done_d  = 1'b0;
               data_done_d = 1'b0;
               wr_addr_d   = wr_tuser_in ? STEP_C : next_addr(wr_addr_q);
               state_d     = calib_in ? IDLE : WAIT_CAL;
            end
         end
         READ: begin
            app_en   = 1'b1;
            app_cmd  = CMD_READ;
            app_addr = ADDR_W'(rd_addr_q);
            if (app_rdy) begin
               rd_issue  = 1'b1;
               rd_addr_d = next_addr(rd_addr_q);
               state_d   = calib_in ? IDLE : WAIT_CAL;
            end
         end
      endcase
   end

   // FSM, address counters and write handshake tracking
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= WAIT_CAL;
         last_grant_q <= GRANT_RD;
         cmd_done_q   <= 1'b0;
         data_done_q  <= 1'b0;
         wr_addr_q    <= '0;
         rd_addr_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cmd_done_q   <= cmd_done_d;
         data_done_q  <= data_done_d;
         wr_addr_q    <= wr_addr_d;
         rd_addr_q    <= rd_addr_d;
      end
   end

   // reads in flight and frame position of returning beats
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         outstanding_q <= '0;
         rd_ret_cnt_q  <= '0;
      end else begin
         if (rd_issue && !app_rd_data_valid)      outstanding_q <= outstanding_q + 1'b1;
         else if (!rd_issue && app_rd_data_valid) outstanding_q <= outstanding_q - 1'b1;
         if (app_rd_data_valid) rd_ret_cnt_q <= (rd_ret_cnt_q == LAST_PHR) ? '0 : rd_ret_cnt_q + 1'b1;
      end
   end

   rd_return_fifo #(
      .WIDTH (129),
      .DEPTH (RD_FIFO_DEPTH)
   ) u_rd_fifo (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .push_in      (app_rd_data_valid),
      .push_data_in ({rd_ret_cnt_q == '0, app_rd_data}),
      .pop_in       (rd_ready_out),
      .pop_data_out (fifo_dout),
      .valid_out    (rd_valid_out),
      .count_out    (fifo_cnt)
   );

endmodule
